// File: rtl/bcd_scan_pkg.sv
// Shared types and helpers for the BCD scan controller: the scan state
// encoding and the BCD legality test.
package bcd_scan_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        GUARD = 2'd2
    } scan_state_e;

    localparam logic [3:0] BCD_MAX = 4'd9;

    function automatic logic is_bcd_legal(input logic [3:0] value);
        return value <= BCD_MAX;
    endfunction

endpackage

// File: rtl/bcd_digit_regfile.sv
// Digit storage for the scan controller: write port, sticky illegal-code flag,
// read mux and, with BCD_LZB_EN defined, the leading-zero blank for the read slot.
module bcd_digit_regfile
    import bcd_scan_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int IDX_W      = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [3:0]       wr_data,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [3:0]       rd_data,
    output logic             rd_legal,
    output logic             rd_lz,
    output logic             err_code
);

    logic [3:0] digits_q [NUM_DIGITS];
    logic [3:0] digits_d [NUM_DIGITS];
    logic       err_q;
    logic       err_d;

    // Out-of-range indices are dropped entirely, including the error flag.
    always_comb begin
        for (int i = 0; i < NUM_DIGITS; i++) begin
            digits_d[i] = digits_q[i];
        end
        err_d = err_q;
        if (wr_en && (32'(wr_idx) < NUM_DIGITS)) begin
            digits_d[wr_idx] = wr_data;
            if (!is_bcd_legal(wr_data)) begin
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                digits_q[i] <= 4'd0;
            end
            err_q <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                digits_q[i] <= digits_d[i];
            end
            err_q <= err_d;
        end
    end

    assign rd_data  = digits_q[rd_idx];
    assign rd_legal = is_bcd_legal(rd_data);
    assign err_code = err_q;

`ifdef BCD_LZB_EN
    logic [NUM_DIGITS-1:0] lz_mask;

    // Slot i is a leading zero when it and every more significant slot hold 0;
    // slot 0 is never masked so a lone "0" still shows.
    always_comb begin
        logic zeros_above;
        zeros_above = 1'b1;
        lz_mask     = '0;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            zeros_above = zeros_above && (digits_q[i] == 4'd0);
            lz_mask[i]  = zeros_above;
        end
    end

    assign rd_lz = lz_mask[rd_idx];
`else
    assign rd_lz = 1'b0;
`endif

endmodule

// File: rtl/bcd_scan_ctrl.sv
// Round-robin scan controller sharing one BCD decoder among NUM_DIGITS digits,
// with guard blanking between slots. Define BCD_LZB_EN for leading-zero blanking.
module bcd_scan_ctrl
    import bcd_scan_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int SCAN_DIV   = 1000,
    parameter int GUARD_CYC  = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          en,
    input  logic                          load_valid,
    output logic                          load_ready,
    input  logic [$clog2(NUM_DIGITS)-1:0] load_idx,
    input  logic [3:0]                    load_data,
    output logic                          a,
    output logic                          b,
    output logic                          c,
    output logic                          d,
    output logic [NUM_DIGITS-1:0]         digit_sel,
    output logic                          blank,
    output logic                          err_code,
    output logic                          scan_tick
);

    localparam int IDX_W   = $clog2(NUM_DIGITS);
    localparam int CNT_MAX = (SCAN_DIV > GUARD_CYC) ? SCAN_DIV : GUARD_CYC;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CNT_W-1:0] SCAN_LAST  = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] GUARD_LAST = CNT_W'(GUARD_CYC - 1);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

    scan_state_e           state_q, state_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;

    logic [3:0]            abcd_q, abcd_d;
    logic [NUM_DIGITS-1:0] sel_q, sel_d;
    logic                  blank_q, blank_d;
    logic                  tick_q, tick_d;
    logic                  load_ready_q, load_ready_d;

    logic [3:0]            rd_data;
    logic                  rd_legal;
    logic                  rd_lz;
    logic                  wr_en;

    // Handshake: a write transfers on a rising edge where load_valid and
    // load_ready are both high; load_ready drops only for the cycle after reset.
    assign wr_en = load_valid && load_ready_q;

    bcd_digit_regfile #(
        .NUM_DIGITS (NUM_DIGITS),
        .IDX_W      (IDX_W)
    ) u_regfile (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_en),
        .wr_idx   (load_idx),
        .wr_data  (load_data),
        .rd_idx   (idx_q),
        .rd_data  (rd_data),
        .rd_legal (rd_legal),
        .rd_lz    (rd_lz),
        .err_code (err_code)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        if (!en) begin
            state_d = IDLE;
            idx_d   = '0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = DRIVE;
                    idx_d   = '0;
                    cnt_d   = '0;
                end
                DRIVE: begin
                    if (cnt_q == SCAN_LAST) begin
                        state_d = GUARD;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                GUARD: begin
                    if (cnt_q == GUARD_LAST) begin
                        state_d = DRIVE;
                        cnt_d   = '0;
                        idx_d   = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d = IDLE;
                    idx_d   = '0;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Outputs are registered from the current state, so they trail the state by one edge.
    always_comb begin
        abcd_d       = abcd_q;
        sel_d        = '0;
        blank_d      = 1'b1;
        tick_d       = 1'b0;
        load_ready_d = 1'b1;
        if (en) begin
            case (state_q)
                DRIVE: begin
                    abcd_d = rd_data;
                    if (rd_legal && !rd_lz) begin
                        sel_d[idx_q] = 1'b1;
                        blank_d      = 1'b0;
                    end
                end
                GUARD: begin
                    tick_d = (cnt_q == GUARD_LAST) && (idx_q == IDX_LAST);
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            abcd_q       <= 4'd0;
            sel_q        <= '0;
            blank_q      <= 1'b1;
            tick_q       <= 1'b0;
            load_ready_q <= 1'b0;
        end else begin
            abcd_q       <= abcd_d;
            sel_q        <= sel_d;
            blank_q      <= blank_d;
            tick_q       <= tick_d;
            load_ready_q <= load_ready_d;
        end
    end

    assign {a, b, c, d} = abcd_q;
    assign digit_sel    = sel_q;
    assign blank        = blank_q;
    assign scan_tick    = tick_q;
    assign load_ready   = load_ready_q;

endmodule

// File: tb/tb_bcd_scan_ctrl.sv
// Self-checking bench for bcd_scan_ctrl: directed steps plus random writes,
// compared every cycle against a slot-arithmetic reference model.
module tb_bcd_scan_ctrl;

    localparam int N     = 4;
    localparam int S     = 4;
    localparam int G     = 2;
    localparam int SLOT  = S + G;
    localparam int FRAME = N * SLOT;

    logic         clk = 1'b0;
    logic         rst;
    logic         en;
    logic         load_valid;
    logic         load_ready;
    logic [1:0]   load_idx;
    logic [3:0]   load_data;
    logic         a, b, c, d;
    logic [N-1:0] digit_sel;
    logic         blank;
    logic         err_code;
    logic         scan_tick;

    int errors = 0;
    int checks = 0;

    // Reference model: phase is the position within the frame, -1 when idle.
    int           m_dig [N];
    int           m_phase;
    logic [3:0]   m_abcd;
    logic [N-1:0] m_sel;
    logic         m_blank, m_err, m_tick, m_ready;
    logic [3:0]   exp_q [$];

    bcd_scan_ctrl #(
        .NUM_DIGITS (N),
        .SCAN_DIV   (S),
        .GUARD_CYC  (G)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .load_idx   (load_idx),
        .load_data  (load_data),
        .a          (a),
        .b          (b),
        .c          (c),
        .d          (d),
        .digit_sel  (digit_sel),
        .blank      (blank),
        .err_code   (err_code),
        .scan_tick  (scan_tick)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic bit lz_blank(input int slot);
        bit hide;
        hide = 1'b0;
`ifdef BCD_LZB_EN
        hide = (slot != 0);
        for (int j = slot; j < N; j++) begin
            if (m_dig[j] != 0) hide = 1'b0;
        end
`endif
        return hide;
    endfunction

    // Advance the model by one edge using the inputs now applied, then clock and compare.
    task automatic step();
        int slot, w, dv;
        if (rst) begin
            for (int i = 0; i < N; i++) m_dig[i] = 0;
            m_phase = -1;
            m_abcd  = 4'd0;
            m_sel   = '0;
            m_blank = 1'b1;
            m_err   = 1'b0;
            m_tick  = 1'b0;
            m_ready = 1'b0;
        end else begin
            m_sel   = '0;
            m_blank = 1'b1;
            m_tick  = 1'b0;
            if (!en) begin
                m_phase = -1;
            end else if (m_phase < 0) begin
                m_phase = 0;
            end else begin
                slot = m_phase / SLOT;
                w    = m_phase % SLOT;
                if (w < S) begin
                    dv     = m_dig[slot];
                    m_abcd = 4'(dv);
                    if (dv <= 9 && !lz_blank(slot)) begin
                        m_sel   = N'(1) << slot;
                        m_blank = 1'b0;
                    end
                end
                m_tick  = (m_phase == FRAME - 1);
                m_phase = (m_phase + 1) % FRAME;
            end
            if (load_valid && m_ready) begin
                m_dig[load_idx] = int'(load_data);
                if (load_data > 4'd9) m_err = 1'b1;
            end
            m_ready = 1'b1;
        end
        exp_q.push_back(m_abcd);
        @(posedge clk);
        #1;
        check("abcd", 8'({a, b, c, d}), 8'(exp_q.pop_front()));
        check("digit_sel", 8'(digit_sel), 8'(m_sel));
        check("blank", 8'(blank), 8'(m_blank));
        check("err_code", 8'(err_code), 8'(m_err));
        check("scan_tick", 8'(scan_tick), 8'(m_tick));
        check("load_ready", 8'(load_ready), 8'(m_ready));
    endtask

    task automatic write(input int idx, input int data);
        load_valid = 1'b1;
        load_idx   = 2'(idx);
        load_data  = 4'(data);
        step();
        load_valid = 1'b0;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic wait_phase(input int target, input string tag);
        int budget;
        budget = 4 * FRAME;
        while (m_phase != target && budget > 0) begin
            step();
            budget--;
        end
        checks++;
        if (m_phase != target) begin
            errors++;
            $display("FAIL %s phase wait expired observed=%0d expected=%0d", tag, m_phase, target);
        end
    endtask

    initial begin
        rst        = 1'b1;
        en         = 1'b0;
        load_valid = 1'b0;
        load_idx   = 2'd0;
        load_data  = 4'd0;

        run(3);
        rst = 1'b0;
        run(2);

        write(0, 3);
        write(1, 7);
        write(2, 0);
        write(3, 9);
        en = 1'b1;
        run(2 * FRAME + 3);

        write(1, 12);
        run(FRAME);
        write(1, 7);
        run(FRAME);

        wait_phase(1, "live_update");
        write(0, 5);
        run(FRAME);

        wait_phase(2 * SLOT + 1, "en_drop");
        en = 1'b0;
        run(3);
        en = 1'b1;
        run(FRAME + 2);

        wait_phase(S + 1, "rst_in_guard");
        rst = 1'b1;
        step();
        rst = 1'b0;
        run(2);

        write(0, 4);
        write(1, 0);
        write(2, 0);
        write(3, 0);
        run(FRAME + 2);
        write(0, 0);
        run(FRAME + 2);

        for (int i = 0; i < 600; i++) begin
            rst = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 49) == 0) en = ~en;
            load_valid = ($urandom_range(0, 9) < 3);
            load_idx   = 2'($urandom_range(0, N - 1));
            load_data  = ($urandom_range(0, 9) < 8) ? 4'($urandom_range(0, 9))
                                                   : 4'($urandom_range(10, 15));
            step();
        end
        rst        = 1'b0;
        load_valid = 1'b0;
        en         = 1'b1;
        run(FRAME);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bcd_scan_ctrl.md
Name: bcd_scan_ctrl

Overview:
Time-multiplexing controller that shares one BCD_to_decimal decoder among NUM_DIGITS stored BCD digits. It holds a digit register file written through a valid/ready port. It scans the digits round-robin, driving the decoder's a,b,c,d inputs (a = MSB, d = LSB) plus a one-hot digit select. A guard interval between digits suppresses ghosting. It sits between the digit-producing logic (counters, FSMs) and the shared decoder/display.

Parameters:
NUM_DIGITS, 4, number of digits scanned (2..8)
SCAN_DIV, 1000, clock cycles each digit is driven (>=2)
GUARD_CYC, 2, blank cycles inserted between digits (>=1)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous reset, active-high
en  input  1  scan enable; 0 forces IDLE
load_valid  input  1  write request
load_ready  output  1  write accepted when valid&ready
load_idx  input  $clog2(NUM_DIGITS)  target digit index
load_data  input  4  BCD value {a,b,c,d}
a  output  1  BCD bit 3 to decoder
b  output  1  BCD bit 2
c  output  1  BCD bit 1
d  output  1  BCD bit 0
digit_sel  output  NUM_DIGITS  one-hot active digit; all-zero when blank
blank  output  1  1 = decoder outputs must be ignored/suppressed
err_code  output  1  sticky: an illegal code (10..15) was loaded
scan_tick  output  1  one-cycle pulse when the scan wraps from last digit to digit 0

Behaviour:
- Reset (rst=1 at clk edge): all digit regs = 0, state = IDLE, a..d = 0, digit_sel = 0, blank = 1, err_code = 0, scan_tick = 0, load_ready = 0. Reset wins over all other inputs; mid-scan reset aborts the scan immediately.
- All outputs are registered and change only on rising clk.
- load_ready = ~rst_q: low in the cycle following reset, high otherwise, including during IDLE.
- Write: on valid&ready, digit[load_idx] <= load_data at that edge.
  - If load_idx >= NUM_DIGITS, the write is dropped.
  - If load_data > 9, it is stored as-is and err_code is set (sticky until rst).
- States:
  - IDLE: blank = 1, digit_sel = 0. If en = 1, go to DRIVE with idx = 0 and counter = 0.
  - DRIVE: {a,b,c,d} = digit[idx], digit_sel = 1<<idx, blank = 0. The counter counts to SCAN_DIV-1, then go to GUARD.
    - If digit[idx] > 9, blank = 1 and digit_sel = 0 for this slot; the slot timing is unchanged.
  - GUARD: blank = 1, digit_sel = 0, a..d hold their last value for GUARD_CYC cycles. Then idx = (idx + 1) mod NUM_DIGITS and go to DRIVE.
    - scan_tick pulses on the GUARD->DRIVE transition where idx wraps to 0.
- Latency: with en = 1 from reset release, the first DRIVE output appears at edge 2 (IDLE at edge 1). Full frame = NUM_DIGITS*(SCAN_DIV+GUARD_CYC) cycles.
- Write to the digit currently in DRIVE: the new value appears on a..d at the edge after the write edge. The slot counter is not restarted.
- en falling in any state: the next edge enters IDLE and idx resets to 0. Digit regs are retained.
- Counter width = $clog2(max(SCAN_DIV, GUARD_CYC)). No overflow is possible because terminal counts are compared exactly.

Optional Feature:
BCD_LZB_EN
- Defined: leading-zero blanking. During DRIVE of digit idx (idx = NUM_DIGITS-1 is most significant), blank = 1 and digit_sel = 0 if digit[idx] and all higher digits are 0.
  - Digit 0 is never blanked, so "0" still shows.
  - Slot timing is unchanged.
- Undefined: all legal digits are displayed, including leading zeros.

Decomposition:
- Package bcd_scan_pkg holds:
  - state enum {IDLE, DRIVE, GUARD}
  - localparam BCD_MAX = 4'd9
  - function is_bcd_legal(4-bit)
- One natural sub-module, bcd_digit_regfile: NUM_DIGITS x 4 storage, write port, legality flag, read mux by idx, and the leading-zero mask when BCD_LZB_EN is defined.
- The FSM and counter stay in bcd_scan_ctrl.

Test Plan:
- Reset/idle: rst=1 for 3 cycles, en=0 → blank=1, digit_sel=0, a..d=0, load_ready=0 the cycle after reset, then 1.
- Basic scan: SCAN_DIV=4, GUARD_CYC=2. Load digits {3,7,0,9} to idx 0..3, en=1 → digit_sel 0001 with abcd=0011 for 4 cycles, 2 blank cycles, then 0010 with abcd=0111, and so on. scan_tick pulses once every 24 cycles.
- Illegal code: load idx1 = 4'hC → err_code=1 sticky. Slot 1 is blank with digit_sel=0 and keeps its 4-cycle length. Reloading a legal value does not clear err_code; only rst does.
- Live update: write idx0 = 5 during cycle 2 of digit 0's DRIVE → abcd=0101 on the next edge, and the slot still ends at 4 cycles.
- Disable/reset mid-scan: drop en during digit 2 → IDLE next edge, blank=1. Re-raising en restarts at digit 0 with retained values. rst during GUARD → all outputs at reset values next edge.
- BCD_LZB_EN: digits {4,0,0,0} (idx0=4) → slots 3, 2, 1 blank, slot 0 shows 0100. Digits {0,0,0,0} → only slot 0 drives abcd=0000.
